// File: rtl/spike_net_interface_pkg.sv
// Shared flit layout, port indices, FSM encodings and routing-entry type
// for the spike network interface (the router uses the same field positions).
package spike_net_interface_pkg;

   localparam int DEST_X_HI = 31;
   localparam int DEST_X_LO = 24;
   localparam int DEST_Y_HI = 23;
   localparam int DEST_Y_LO = 16;
   localparam int AXON_HI   = 15;
   localparam int AXON_LO   = 8;
   localparam int SRC_HI    = 7;
   localparam int SRC_LO    = 0;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_NORTH = 1;
   localparam int PORT_EAST  = 2;
   localparam int PORT_SOUTH = 3;
   localparam int PORT_WEST  = 4;

   localparam int CFG_W = 25;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_SEND = 2'd2
   } ni_state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] dest_x;
      logic [7:0] dest_y;
      logic [7:0] axon;
   } route_entry_t;

   function automatic logic [31:0] make_flit(input route_entry_t e, input logic [7:0] src);
      logic [31:0] f;
      f                    = '0;
      f[DEST_X_HI:DEST_X_LO] = e.dest_x;
      f[DEST_Y_HI:DEST_Y_LO] = e.dest_y;
      f[AXON_HI:AXON_LO]     = e.axon;
      f[SRC_HI:SRC_LO]       = src;
      return f;
   endfunction

endpackage

// File: rtl/spike_net_interface_fifo.sv
// ni_spike_fifo: synchronous FIFO with show-ahead read data; push ignored
// when full, pop ignored when empty.
module ni_spike_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/spike_net_interface.sv
// Injection network interface: buffers spikes, expands each into one flit per
// valid routing slot. Optional NI_DROP_CNT_EN adds a saturating drop counter.
module spike_net_interface
   import spike_net_interface_pkg::*;
#(
   parameter  int DATA_WIDTH  = 32,
   parameter  int NUM_NEURONS = 16,
   parameter  int FANOUT      = 4,
   parameter  int FIFO_DEPTH  = 8,
   localparam int NID_W       = $clog2(NUM_NEURONS),
   localparam int SLOT_W      = (FANOUT > 1) ? $clog2(FANOUT) : 1,
   localparam int TBL_N       = NUM_NEURONS * FANOUT,
   localparam int TA_W        = $clog2(TBL_N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spike_valid,
   input  logic [NID_W-1:0]      spike_id,
   output logic                  spike_ready,
   input  logic                  cfg_we,
   input  logic [TA_W-1:0]       cfg_addr,
   input  logic [CFG_W-1:0]      cfg_wdata,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  vout,
   input  logic                  rin,
`ifdef NI_DROP_CNT_EN
   output logic                  busy,
   output logic [15:0]           drop_count
`else
   output logic                  busy
`endif
);

   ni_state_e             state_q, state_d;
   logic [NID_W-1:0]      cur_id_q, cur_id_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  vout_q, vout_d;

   logic                  fifo_pop, fifo_full, fifo_empty;
   logic [NID_W-1:0]      fifo_rdata;

   route_entry_t          tbl_q [TBL_N];
   route_entry_t          rd_ent;
   logic [TA_W-1:0]       rd_idx;
   logic                  last_slot;

   ni_spike_fifo #(.WIDTH(NID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (spike_valid),
      .wdata_i (spike_id),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Only the valid bits need clearing; stale payloads are never observed.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TBL_N; i++) tbl_q[i].valid <= 1'b0;
      end else if (cfg_we && (int'(cfg_addr) < TBL_N)) begin
         tbl_q[cfg_addr] <= route_entry_t'(cfg_wdata);
      end
   end

   assign rd_idx    = TA_W'(int'(cur_id_q) * FANOUT + int'(slot_q));
   assign rd_ent    = tbl_q[rd_idx];
   assign last_slot = (int'(slot_q) == FANOUT - 1);
   assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cur_id_q <= '0;
         slot_q   <= '0;
         dout_q   <= '0;
         vout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_id_q <= cur_id_d;
         slot_q   <= slot_d;
         dout_q   <= dout_d;
         vout_q   <= vout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_SCAN;
         ST_SCAN: begin
            if (rd_ent.valid)   state_d = ST_SEND;
            else if (last_slot) state_d = ST_IDLE;
         end
         ST_SEND: if (rin) state_d = last_slot ? ST_IDLE : ST_SCAN;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cur_id_d = cur_id_q;
      slot_d   = slot_q;
      dout_d   = dout_q;
      vout_d   = vout_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               cur_id_d = fifo_rdata;
               slot_d   = '0;
            end
         end
         ST_SCAN: begin
            if (rd_ent.valid) begin
               dout_d = make_flit(rd_ent, 8'(cur_id_q));
               vout_d = 1'b1;
            end else if (!last_slot) begin
               slot_d = slot_q + 1'b1;
            end
         end
         ST_SEND: begin
            if (rin) begin
               vout_d = 1'b0;
               if (!last_slot) slot_d = slot_q + 1'b1;
            end
         end
         default: vout_d = 1'b0;
      endcase
   end

   assign dout        = dout_q;
   assign vout        = vout_q;
   assign spike_ready = !fifo_full;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;

`ifdef NI_DROP_CNT_EN
   logic [15:0] drop_q;

   always_ff @(posedge clk) begin
      if (rst)                                             drop_q <= '0;
      else if (spike_valid && fifo_full && (drop_q != '1)) drop_q <= drop_q + 1'b1;
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_spike_net_interface.sv
// Self-checking bench for spike_net_interface: directed scenarios plus
// randomized rounds checked against a table/queue model of the flit stream.
module tb_spike_net_interface;

   localparam int NN = 16;
   localparam int F  = 4;
   localparam int FD = 8;

   logic        clk = 1'b0;
   logic        rst, spike_valid, spike_ready, cfg_we, vout, rin, busy;
   logic [3:0]  spike_id;
   logic [5:0]  cfg_addr;
   logic [24:0] cfg_wdata;
   logic [31:0] dout;
`ifdef NI_DROP_CNT_EN
   logic [15:0] drop_count;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [24:0] tb_tbl [NN*F];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   int          got_cyc [$];

   spike_net_interface #(.DATA_WIDTH(32), .NUM_NEURONS(NN), .FANOUT(F), .FIFO_DEPTH(FD)) dut (
      .clk         (clk),
      .rst         (rst),
      .spike_valid (spike_valid),
      .spike_id    (spike_id),
      .spike_ready (spike_ready),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .dout        (dout),
      .vout        (vout),
      .rin         (rin),
`ifdef NI_DROP_CNT_EN
      .busy        (busy),
      .drop_count  (drop_count)
`else
      .busy        (busy)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Inputs only change 1ns after a rising edge, so negedge values are the ones the next edge sees.
   always @(negedge clk) begin
      if (!rst && vout && rin) begin
         got_q.push_back(dout);
         got_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NN*F; i++) tb_tbl[i] = '0;
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   task automatic cfg_write(input int id, input int slot, input logic [24:0] w);
      cfg_we    = 1'b1;
      cfg_addr  = 6'(id*F + slot);
      cfg_wdata = w;
      tick();
      cfg_we = 1'b0;
      tb_tbl[id*F + slot] = w;
   endtask

   task automatic send_spike(input int id);
      spike_valid = 1'b1;
      spike_id    = 4'(id);
      tick();
      spike_valid = 1'b0;
   endtask

   task automatic expect_spike(input int id);
      for (int s = 0; s < F; s++)
         if (tb_tbl[id*F + s][24]) exp_q.push_back({tb_tbl[id*F + s][23:0], 8'(id)});
   endtask

   task automatic wait_vout(input string name);
      int n = 0;
      while (!vout && n < 40) begin
         tick();
         n++;
      end
      if (!vout) begin
         bad++;
         $display("FAIL %s: vout=%0b after %0d cycles, required 1", name, vout, n);
      end
   endtask

   task automatic wait_idle(input int max, input bit rnd, input string name);
      int n = 0;
      while (busy && n < max) begin
         rin = rnd ? 1'($urandom_range(1)) : 1'b1;
         tick();
         n++;
      end
      total++;
      if (busy) begin
         bad++;
         $display("FAIL %s_drain: busy=%0b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; spike_valid = 1'b0; spike_id = '0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_wdata = '0; rin = 1'b0;
      tick(); tick();
      total++;
      if ({vout, busy, spike_ready} !== 3'b001 || dout !== 32'h0) begin
         bad++;
         $display("FAIL reset: vout/busy/ready=%b dout=%h, required 001 and 00000000",
                  {vout, busy, spike_ready}, dout);
      end
`ifdef NI_DROP_CNT_EN
      total++;
      if (drop_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_drop: drop_count=%0d required 0", drop_count);
      end
`endif
      reset_dut();
   endtask

   task automatic test_basic();
      int t0;
      cfg_write(3, 0, {1'b1, 8'h02, 8'h01, 8'h05});
      cfg_write(3, 2, {1'b1, 8'h00, 8'h00, 8'h09});
      rin = 1'b1;
      got_q.delete(); got_cyc.delete();
      send_spike(3);
      t0 = cyc;
      tick();
      total++;
      if (vout !== 1'b0) begin
         bad++;
         $display("FAIL basic_early: vout=%0b one edge after accept, required 0", vout);
      end
      tick();
      total++;
      if (vout !== 1'b1 || dout !== 32'h02010503) begin
         bad++;
         $display("FAIL basic_latency: vout=%0b dout=%h two edges after accept, required 1 02010503", vout, dout);
      end
      wait_idle(30, 1'b0, "basic");
      total++;
      if (got_q.size() != 2) begin
         bad++;
         $display("FAIL basic_count: got %0d flits, required 2", got_q.size());
      end else begin
         total++;
         if (got_q[0] !== 32'h02010503 || got_q[1] !== 32'h00000903) begin
            bad++;
            $display("FAIL basic_data: got %h %h, required 02010503 00000903", got_q[0], got_q[1]);
         end
         // Handshake edge + SCAN of empty slot 1 + SCAN of slot 2.
         total++;
         if (got_cyc[1] - got_cyc[0] != 3 || got_cyc[0] - t0 != 2) begin
            bad++;
            $display("FAIL basic_timing: first at +%0d gap %0d, required +2 gap 3",
                     got_cyc[0] - t0, got_cyc[1] - got_cyc[0]);
         end
      end
   endtask

   task automatic test_stall();
      rin = 1'b0;
      got_q.delete(); got_cyc.delete();
      send_spike(3);
      wait_vout("stall_start");
      for (int i = 0; i < 5; i++) begin
         total++;
         if (vout !== 1'b1 || dout !== 32'h02010503) begin
            bad++;
            $display("FAIL stall_hold%0d: vout=%0b dout=%h, required 1 02010503", i, vout, dout);
         end
         tick();
      end
      rin = 1'b1;
      tick();
      rin = 1'b0;
      total++;
      if (got_q.size() != 1 || vout !== 1'b0) begin
         bad++;
         $display("FAIL stall_release: flits=%0d vout=%0b, required 1 0", got_q.size(), vout);
      end
      wait_idle(30, 1'b0, "stall");
   endtask

   task automatic test_overflow();
      int errs = 0;
      rin = 1'b0;
      got_q.delete(); got_cyc.delete();
      send_spike(3);
      wait_vout("ovf_start");
      for (int k = 0; k < FD + 1; k++) begin
         spike_valid = 1'b1;
         spike_id    = 4'd3;
         total++;
         if (spike_ready !== (k < FD)) begin
            bad++;
            $display("FAIL ovf_ready%0d: spike_ready=%0b required %0b", k, spike_ready, k < FD);
         end
         tick();
      end
      spike_valid = 1'b0;
`ifdef NI_DROP_CNT_EN
      total++;
      if (drop_count !== 16'd1) begin
         bad++;
         $display("FAIL ovf_drop: drop_count=%0d required 1", drop_count);
      end
`endif
      wait_idle(300, 1'b0, "ovf");
      total++;
      if (got_q.size() != 2*(FD+1)) begin
         bad++;
         $display("FAIL ovf_count: got %0d flits, required %0d", got_q.size(), 2*(FD+1));
      end
      for (int i = 0; i < got_q.size(); i++)
         if (got_q[i] !== ((i % 2 == 0) ? 32'h02010503 : 32'h00000903)) errs++;
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL ovf_data: %0d flits out of order, required 0", errs);
      end
   endtask

   task automatic test_empty_neuron();
      bit seen = 1'b0;
      rin = 1'b1;
      got_q.delete(); got_cyc.delete();
      send_spike(5);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL empty_busy: busy=%0b after accept, required 1", busy);
      end
      for (int i = 0; i < F + 1; i++) begin
         if (vout) seen = 1'b1;
         tick();
      end
      total++;
      if (seen || busy !== 1'b0 || got_q.size() != 0) begin
         bad++;
         $display("FAIL empty_neuron: vout_seen=%0b busy=%0b flits=%0d, required 0 0 0",
                  seen, busy, got_q.size());
      end
   endtask

   task automatic test_reset_midsend();
      rin = 1'b0;
      send_spike(3);
      wait_vout("rst_start");
      rst = 1'b1;
      tick();
      total++;
      if (vout !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_midsend: vout=%0b busy=%0b, required 0 0", vout, busy);
      end
      rst = 1'b0;
      for (int i = 0; i < NN*F; i++) tb_tbl[i] = '0;
      got_q.delete(); got_cyc.delete();
      rin = 1'b1;
      send_spike(3);
      for (int i = 0; i < 10; i++) tick();
      total++;
      if (got_q.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_table: flits=%0d busy=%0b after reset, required 0 0", got_q.size(), busy);
      end
   endtask

   task automatic test_cfg_update();
      reset_dut();
      cfg_write(3, 0, {1'b1, 8'h02, 8'h01, 8'h05});
      cfg_write(3, 1, {1'b1, 8'h11, 8'h22, 8'h33});
      rin = 1'b0;
      send_spike(3);
      wait_vout("cfg_start");
      cfg_write(3, 1, {1'b1, 8'h44, 8'h55, 8'h66});
      total++;
      if (vout !== 1'b1 || dout !== 32'h02010503) begin
         bad++;
         $display("FAIL cfg_inflight: vout=%0b dout=%h, required 1 02010503", vout, dout);
      end
      wait_idle(30, 1'b0, "cfg");
      total++;
      if (got_q.size() != 2 || got_q[got_q.size()-1] !== 32'h44556603) begin
         bad++;
         $display("FAIL cfg_new: flits=%0d last=%h, required 2 44556603",
                  got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'h0);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int nsp, errs;
         reset_dut();
         for (int id = 0; id < NN; id++)
            for (int s = 0; s < F; s++) begin
               logic        v;
               logic [23:0] pl;
               v  = ($urandom_range(2) == 0);
               pl = 24'($urandom);
               cfg_write(id, s, {v, pl});
            end
         nsp = 1 + $urandom_range(5);
         for (int k = 0; k < nsp; k++) begin
            int id, gap;
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) begin
               rin = 1'($urandom_range(1));
               tick();
            end
            id  = $urandom_range(NN-1);
            rin = 1'($urandom_range(1));
            total++;
            if (spike_ready !== 1'b1) begin
               bad++;
               $display("FAIL rnd%0d_ready: spike_ready=%0b with few queued, required 1", r, spike_ready);
            end
            expect_spike(id);
            send_spike(id);
         end
         wait_idle(600, 1'b1, "rnd");
         errs = 0;
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) errs++;
         total++;
         if (got_q.size() != exp_q.size() || errs != 0) begin
            bad++;
            $display("FAIL rnd%0d_stream: got %0d flits (%0d wrong), required %0d matching",
                     r, got_q.size(), errs, exp_q.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_empty_neuron();
      test_reset_midsend();
      test_cfg_update();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
